// File: rtl/aes_pkg.sv
// Shared types and constants for the iterative AES round sequencer.
package aes_pkg;

  // Sequencer states. S0..S3 are the four stage slots of one round.
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WAIT_KEY = 3'd1,
    ST_LOAD     = 3'd2,
    ST_S0       = 3'd3,
    ST_S1       = 3'd4,
    ST_S2       = 3'd5,
    ST_S3       = 3'd6,
    ST_DONE     = 3'd7
  } state_e;

  // Datapath stage selected in the current cycle. At most one is active.
  typedef enum logic [2:0] {
    STG_NONE = 3'd0,
    STG_LD   = 3'd1,
    STG_SB   = 3'd2,
    STG_SR   = 3'd3,
    STG_MC   = 3'd4,
    STG_ARK  = 3'd5
  } stage_e;

  // Round counts for the three key lengths.
  localparam int NR_128 = 10;
  localparam int NR_192 = 12;
  localparam int NR_256 = 14;

  // Stage order within a full round, cipher direction.
  localparam stage_e ENC_S0 = STG_SB;
  localparam stage_e ENC_S1 = STG_SR;
  localparam stage_e ENC_S2 = STG_MC;
  localparam stage_e ENC_S3 = STG_ARK;

  // Stage order within a full round, inverse direction.
  localparam stage_e DEC_S0 = STG_SR;
  localparam stage_e DEC_S1 = STG_SB;
  localparam stage_e DEC_S2 = STG_ARK;
  localparam stage_e DEC_S3 = STG_MC;

  // Round-key index used in a given round: keys run forward for the
  // cipher and backward for the inverse cipher.
  function automatic int unsigned key_index(logic enc, int unsigned rnd,
                                            int unsigned nr);
    return enc ? rnd : nr - rnd;
  endfunction

endpackage

// File: rtl/aes_round_ctrl.sv
// Round sequencer for the iterative AES core: walks the load, substitution,
// shift-rows, mix-columns and add-round-key stages one enable per cycle and
// tracks round number, round-key index and cipher/inverse mode.
module aes_round_ctrl
  import aes_pkg::*;
#(
  parameter int NR = 10,
  parameter int KW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          encode,
  input  logic          key_ready,
  output logic          busy,
  output logic          done,
  output logic          sb_encode,
  output logic          ld_en,
  output logic          sb_en,
  output logic          sr_en,
  output logic          mc_en,
  output logic          ark_en,
  output logic [KW-1:0] round,
  output logic [KW-1:0] key_idx,
  output logic          last_round
);

  localparam logic [KW-1:0] NR_K  = KW'(NR);
  localparam bit            NR_OK = (NR == NR_128) || (NR == NR_192) ||
                                    (NR == NR_256);

  state_e        state_q, state_d;
  logic          mode_q;
  logic [KW-1:0] round_q;
  logic [KW-1:0] kidx_q;
  stage_e        stage;
  logic          accept;
  logic          advance;

  assign last_round = (round_q == NR_K);
  assign accept     = (state_q == ST_IDLE) && start;
  // The round counter steps when leaving LOAD and at the end of every
  // full round; the last round never reaches S3.
  assign advance    = (state_q == ST_LOAD) || (state_q == ST_S3);

  // Next-state sequencing; key_ready only matters before LOAD.
  always_comb begin
    // NOTE: assigning a default first keeps every path covered, so no latch.
    state_d = state_q;
    case (state_q)
      ST_IDLE:     if (start) state_d = key_ready ? ST_LOAD : ST_WAIT_KEY;
      ST_WAIT_KEY: if (key_ready) state_d = ST_LOAD;
      ST_LOAD:     state_d = ST_S0;
      ST_S0:       state_d = ST_S1;
      ST_S1:       state_d = ST_S2;
      ST_S2:       state_d = last_round ? ST_DONE : ST_S3;
      ST_S3:       state_d = ST_S0;
      ST_DONE:     state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  // State, mode, round and key-index registers.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state_q <= ST_IDLE;
      mode_q  <= 1'b0;
      round_q <= '0;
      kidx_q  <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        mode_q  <= encode;
        round_q <= '0;
        kidx_q  <= KW'(key_index(encode, 0, NR));
      end else if (advance) begin
        round_q <= round_q + KW'(1);
        kidx_q  <= KW'(key_index(mode_q, 32'(round_q) + 1, NR));
      end
    end
  end

  // Stage decode from mode, state slot and last-round flag. The last round
  // drops mix-columns: the cipher puts add-round-key into S2, the inverse
  // already has it there and simply ends the round.
  always_comb begin
    stage = STG_NONE;
    casez ({mode_q, state_q, last_round})
      {1'b?, ST_LOAD, 1'b?}: stage = STG_LD;
      {1'b1, ST_S0,   1'b?}: stage = ENC_S0;
      {1'b1, ST_S1,   1'b?}: stage = ENC_S1;
      {1'b1, ST_S2,   1'b0}: stage = ENC_S2;
      {1'b1, ST_S2,   1'b1}: stage = STG_ARK;
      {1'b1, ST_S3,   1'b?}: stage = ENC_S3;
      {1'b0, ST_S0,   1'b?}: stage = DEC_S0;
      {1'b0, ST_S1,   1'b?}: stage = DEC_S1;
      {1'b0, ST_S2,   1'b?}: stage = DEC_S2;
      {1'b0, ST_S3,   1'b?}: stage = DEC_S3;
      default:               stage = STG_NONE;
    endcase
  end

  assign ld_en     = (stage == STG_LD);
  assign sb_en     = (stage == STG_SB);
  assign sr_en     = (stage == STG_SR);
  assign mc_en     = (stage == STG_MC);
  assign ark_en    = (stage == STG_ARK);
  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);
  assign sb_encode = mode_q;
  assign round     = round_q;
  assign key_idx   = kidx_q;

  // Structural guarantees the datapath relies on.
  a_nr_legal: assert property (@(posedge clk) disable iff (rst) NR_OK);
  a_onehot:   assert property (@(posedge clk)
                $onehot0({ld_en, sb_en, sr_en, mc_en, ark_en}));
  a_done:     assert property (@(posedge clk) disable iff (rst)
                done |=> !done && !busy);
  a_round:    assert property (@(posedge clk) disable iff (rst)
                round_q <= NR_K);

endmodule

// File: doc/aes_round_ctrl.md
# aes_round_ctrl

Round sequencer for the iterative AES core. It drives the shared byte-substitution stage and the shift-rows, mix-columns and add-round-key stages, one stage enable per cycle. It also tracks the round count, selects the round-key index and sets the forward/inverse mode. It sits between the host start/done handshake and the 128-bit state datapath, and owns no data itself.

## Interface
- NR, default 10: number of rounds. Legal values are 10, 12 and 14.
- KW, default 4: width of round counter and key index.
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request a block operation. Sampled only in IDLE.
- encode  in  1  1 = cipher, 0 = inverse cipher. Latched when start is accepted.
- key_ready  in  1  key schedule holds all round keys.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when the result is in the state register.
- sb_encode  out  1  latched mode. Drives the substitution unit's encode select.
- ld_en  out  1  load input block XOR round key 0 (cipher) or round key NR (inverse).
- sb_en, sr_en, mc_en, ark_en  out  1 each  stage capture enables. At most one of ld_en, sb_en, sr_en, mc_en, ark_en is high in any cycle.
- round  out  KW  current round, 0..NR.
- key_idx  out  KW  round-key index for ld_en/ark_en. Equals round for the cipher, NR-round for the inverse.
- last_round  out  1  round == NR.

## Operation
States: IDLE, WAIT_KEY, LOAD, S0, S1, S2, S3, DONE.
- IDLE:
  - start=1 latches encode into the mode register and clears round to 0.
  - Next state is LOAD if key_ready=1, otherwise WAIT_KEY.
- WAIT_KEY: hold until key_ready=1, then go to LOAD. All enables stay low.
- LOAD: ld_en=1, then round←1 and go to S0.
- Cipher stage order for S0..S3: sb_en, sr_en, mc_en, ark_en.
- Inverse stage order for S0..S3: sr_en, sb_en, ark_en, mc_en.
- Last round (round==NR) skips the mix-columns stage:
  - Cipher: S2 goes directly to ark_en, i.e. 3 cycles.
  - Inverse: the round ends after ark_en in S2, i.e. 3 cycles.
- End of a round (after the final stage of that round):
  - round<NR: round←round+1 and go to S0.
  - round==NR: go to DONE.
- DONE: done=1 for exactly one cycle, then go to IDLE. round holds NR until the next start.
- start while busy=1 (including the DONE cycle) is ignored and not queued.
- key_ready is checked only in IDLE and WAIT_KEY. A drop later in the operation is ignored.
- encode changes after acceptance have no effect. sb_encode stays constant through DONE.

## Timing
- Reset values: all outputs 0, state IDLE, round 0, sb_encode 0.
- rst asserted mid-operation: IDLE with all outputs 0 on the next edge. No done pulse is produced.
- Latency from the start-accept edge to done high, with key_ready=1: 1 + 4·(NR−1) + 3 + 1 cycles.
  - NR=10: 41 cycles.
  - NR=12: 49 cycles.
  - NR=14: 57 cycles.
- Each cycle spent in WAIT_KEY adds one cycle.
- Back-to-back operation: start may be accepted in the cycle after DONE (IDLE). Minimum period is latency+1.
- All outputs are registered or decoded only from state and round registers. No combinational path from inputs to outputs except through state.
- The substitution unit is combinational. The datapath captures its output on the sb_en edge, so one cycle per stage is sufficient.

## Structure
- Package aes_pkg:
  - state enum.
  - NR_128/NR_192/NR_256 constants.
  - Stage-order constants for both modes.
  - Key-index function.
- Single module. No sub-module is needed; the stage-order decode is a case on {mode, state, last_round}.
- The integration test wraps this block with the existing substitution unit plus shift-rows, mix-columns, add-round-key and the key schedule.

## Test plan
- Reset, then start=1, encode=1, NR=10, key_ready=1:
  - ld_en at cycle 1.
  - Enable pattern sb,sr,mc,ark repeated 9 times, then sb,sr,ark.
  - done high at cycle 41.
  - key_idx sequence 0,1..10.
- Inverse, NR=10:
  - Pattern sr,sb,ark,mc ×9, then sr,sb,ark.
  - key_idx at ld_en = 10; key_idx sequence continues 9..0.
  - sb_encode=0 throughout.
- key_ready low for 5 cycles after start: WAIT_KEY held for 5 cycles, no enables, done at cycle 46.
- start pulsed at cycle 20 and in the DONE cycle: both ignored. The start in the following IDLE cycle is accepted.
- rst at cycle 17: all outputs 0 next cycle, no done. A new start then completes normally.
- Integrated FIPS-197 vector:
  - key 000102030405060708090a0b0c0d0e0f, plaintext 00112233445566778899aabbccddeeff → ciphertext 69c4e0d86a7b0430d8cdb78070b4c55a.
  - Inverse mode recovers the plaintext.
